pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard, stall and forwarding controller for the pipelined MIPS core, replacing the separate load-use, ID-forward and EXE-forward decoders with one block. It keeps its own scoreboard of in-flight register writers for every stage after ID. From the scoreboard it derives:
- the load-use and branch-operand stalls;
- the IF/ID flush on redirect;
- registered forwarding selects for the EXE operands and combinational selects for the ID branch comparator.

Depth and load latency are generic, so deeper pipelines need no new hazard logic.

## Interface
- N_STG, 3, number of scoreboard stages after ID (1 = EXE, 2 = MEM, ..., N_STG = WB); legal range 2..7
- LOAD_LAT, 1, number of stages past EXE before load data is forwardable (load result first forwardable from stage LOAD_LAT+1)
- RA_W, 5, register-number width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  source registers of ID instruction
- id_use_rs, id_use_rt  in  1  operand actually read
- id_rd  in  RA_W  destination after write-select mux
- id_reg_write  in  1  ID instruction writes GPR
- id_is_load  in  1  ID instruction is lw
- id_branch  in  1  ID instruction compares operands in ID (beq/jr)
- id_redirect  in  1  ID has resolved a taken branch or jump
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EXE
- if_id_flush  out  1  squash IF/ID
- id_fwd_a, id_fwd_b  out  3  ID operand source: 0 = GPR, k = result of stage k (2..N_STG)
- exe_fwd_a, exe_fwd_b  out  3  registered EXE operand source: 0 = ID/EXE value, j = stage j+1 result

## Operation
- Scoreboard entry per stage k holds {valid, rd, is_load}. Each cycle, entries shift k -> k+1, and entry N_STG retires.
- Stage 1 loads {id_valid & id_reg_write & ~stall, id_rd, id_is_load}. On a stall a bubble is loaded into stage 1 instead.
- Match(k, r): valid[k] & rd[k] == r & r != 0. Register 0 never matches. The newest match (smallest k) wins.
- Load-use stall: an used operand whose newest match is a load in stage k <= LOAD_LAT.
- Branch stall: with id_branch, an used operand whose newest match is:
  - in stage 1 (ALU result not yet available); or
  - a load in stage k <= LOAD_LAT+1.
- stall is the OR of the two stall conditions, gated by id_valid.
- id_fwd_x = newest matching k when k >= 2 and no stall. Otherwise it is 0.
- exe_fwd_x is registered at the clock edge:
  - when not stalling: newest match k (in 1..N_STG-1), or 0 if there is none;
  - when stalling: 0, because the bubble has no operands.
  - Matches only in stage N_STG register as 0, because the GPR write-through covers them.
- if_id_flush = id_redirect & ~stall. When stall and redirect are both asserted, stall wins. The branch is re-evaluated next cycle.

## Timing
- Reset values: scoreboard all invalid; stall = 0, if_id_flush = 0, id_fwd_x = 0, exe_fwd_x = 0.
- stall, if_id_flush and id_fwd_x are combinational from the inputs and the scoreboard, with zero latency.
- exe_fwd_x is valid in the cycle the consumer occupies EXE, which is one cycle after its ID decision.
- A load-use stall lasts LOAD_LAT cycles. A branch-after-ALU stall lasts 1 cycle. A branch-after-load stall lasts LOAD_LAT+1 cycles.
- Reset asserted mid-stall clears the scoreboard immediately, and stall drops in the same cycle.
- id_valid = 0 forces stall = 0, id_fwd_x = 0 and a bubble into stage 1.

## Configuration
- HAZ_STATS_EN defined: adds two outputs, stall_cnt (32 bit) and loaduse_cnt (32 bit).
  - stall_cnt increments on every stall cycle; loaduse_cnt increments on the first cycle of each load-use stall.
  - Both wrap at 2^32 and are cleared by reset.
- HAZ_STATS_EN undefined: neither port nor either counter exists.

## Structure
- The shared package hazard_pkg holds:
  - forwarding-select encoding constants FWD_NONE = 0 and stage indices STG_EXE = 1, STG_MEM = 2, STG_WB = 3;
  - the scoreboard entry typedef.
- One sub-module, haz_match: a per-operand newest-match priority encoder returning {hit, stage, is_load}. It is instantiated twice, once per operand.

## Test plan
- Load-use: lw $2 followed by add $3,$2,$4 (N_STG = 3, LOAD_LAT = 1) -> stall = 1 for exactly 1 cycle, then exe_fwd_a = 2 (WB) when add is in EXE.
- ALU chain: add $5 then sub $6,$5,$5 -> stall never asserted; exe_fwd_a = exe_fwd_b = 1 (MEM).
- Branch after ALU: add $7 then beq $7,$0 -> 1-cycle stall, then id_fwd_a = 2. Taken beq -> if_id_flush = 1 only on the non-stalled cycle.
- Register 0: lw $0 then add $1,$0,$0 -> no stall, all forwarding selects 0.
- Reset mid-stall: reset driven to 0 during a load-use stall -> stall = 0 in the same cycle, exe_fwd_x = 0, scoreboard empty after release.
- HAZ_STATS_EN: three load-use pairs -> loaduse_cnt = 3, stall_cnt = 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned FWD_W    = 3;
  // Widest register-number field carried in a scoreboard entry.
  localparam int unsigned RA_W_MAX = 8;

  localparam logic [FWD_W-1:0] FWD_NONE = 3'd0;
  localparam logic [FWD_W-1:0] STG_EXE  = 3'd1;
  localparam logic [FWD_W-1:0] STG_MEM  = 3'd2;
  localparam logic [FWD_W-1:0] STG_WB   = 3'd3;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/haz_match.sv
// Newest-match priority encoder for one source operand against the scoreboard.
module haz_match
  import hazard_pkg::*;
#(
  parameter int unsigned N_STG = 3
) (
  input  sb_entry_t [N_STG:1]  sb,
  input  logic [RA_W_MAX-1:0]  ra,
  output logic                 hit,
  output logic [FWD_W-1:0]     stage,
  output logic                 is_load
);

  // Walk oldest to newest so the smallest matching stage ends up winning.
  always_comb begin
    hit     = 1'b0;
    stage   = FWD_NONE;
    is_load = 1'b0;
    for (int k = int'(N_STG); k >= 1; k--) begin
      if (sb[k].valid && (sb[k].rd == ra) && (ra != '0)) begin
        hit     = 1'b1;
        stage   = FWD_W'(k);
        is_load = sb[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, stall and forwarding controller driven by a private scoreboard of
// in-flight GPR writers. Define HAZ_STATS_EN to add stall_cnt/loaduse_cnt.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned N_STG    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned RA_W     = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            id_branch,
  input  logic            id_redirect,
  output logic            stall,
  output logic            if_id_flush,
  output logic [2:0]      id_fwd_a,
  output logic [2:0]      id_fwd_b,
  output logic [2:0]      exe_fwd_a,
  output logic [2:0]      exe_fwd_b
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     loaduse_cnt
`endif
);

  localparam logic [FWD_W-1:0] LU_MAX     = FWD_W'(LOAD_LAT);
  localparam logic [FWD_W-1:0] BR_LD_MAX  = FWD_W'(LOAD_LAT + 1);
  localparam logic [FWD_W-1:0] EXE_FWD_MX = FWD_W'(N_STG - 1);

  sb_entry_t [N_STG:1] sb;
  sb_entry_t           sb_in;

  logic             hit_a, hit_b;
  logic             ld_a, ld_b;
  logic [FWD_W-1:0] stg_a, stg_b;
  logic             lu_a, lu_b, br_a, br_b;
  logic             lu_stall;
  logic [FWD_W-1:0] exe_nxt_a, exe_nxt_b;

  haz_match #(.N_STG(N_STG)) u_match_a (
    .sb      (sb),
    .ra      (RA_W_MAX'(id_rs)),
    .hit     (hit_a),
    .stage   (stg_a),
    .is_load (ld_a)
  );

  haz_match #(.N_STG(N_STG)) u_match_b (
    .sb      (sb),
    .ra      (RA_W_MAX'(id_rt)),
    .hit     (hit_b),
    .stage   (stg_b),
    .is_load (ld_b)
  );

  // Stall, flush and forwarding decisions for the instruction sitting in ID.
  always_comb begin
    lu_a = id_use_rs & hit_a & ld_a & (stg_a <= LU_MAX);
    lu_b = id_use_rt & hit_b & ld_b & (stg_b <= LU_MAX);
    br_a = id_branch & id_use_rs & hit_a &
           ((stg_a == STG_EXE) | (ld_a & (stg_a <= BR_LD_MAX)));
    br_b = id_branch & id_use_rt & hit_b &
           ((stg_b == STG_EXE) | (ld_b & (stg_b <= BR_LD_MAX)));

    lu_stall    = id_valid & (lu_a | lu_b);
    stall       = id_valid & (lu_a | lu_b | br_a | br_b);
    if_id_flush = id_redirect & ~stall;

    id_fwd_a = (id_valid & ~stall & (stg_a >= STG_MEM)) ? stg_a : FWD_NONE;
    id_fwd_b = (id_valid & ~stall & (stg_b >= STG_MEM)) ? stg_b : FWD_NONE;

    // Producer advances one stage by the time the consumer reaches EXE;
    // a writer already in the last stage is covered by GPR write-through.
    exe_nxt_a = (~stall & hit_a & (stg_a <= EXE_FWD_MX)) ? stg_a : FWD_NONE;
    exe_nxt_b = (~stall & hit_b & (stg_b <= EXE_FWD_MX)) ? stg_b : FWD_NONE;

    sb_in.valid   = id_valid & id_reg_write & ~stall;
    sb_in.rd      = RA_W_MAX'(id_rd);
    sb_in.is_load = id_is_load;
  end

  // Scoreboard shift: new entry (or bubble) into stage 1, last stage retires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb <= '0;
    end else begin
      sb <= {sb[N_STG-1:1], sb_in};
    end
  end

  // EXE operand selects, registered as the consumer moves into EXE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exe_fwd_a <= FWD_NONE;
      exe_fwd_b <= FWD_NONE;
    end else begin
      exe_fwd_a <= exe_nxt_a;
      exe_fwd_b <= exe_nxt_b;
    end
  end

`ifdef HAZ_STATS_EN
  logic lu_stall_q;

  // Stall statistics; a load-use stall is counted once on its first cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      loaduse_cnt <= '0;
      lu_stall_q  <= 1'b0;
    end else begin
      lu_stall_q <= lu_stall;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (lu_stall && !lu_stall_q) begin
        loaduse_cnt <= loaduse_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed hazard scenarios followed
// by random instruction streams, checked against an in-flight writer history.
module tb_pipe_hazard_unit;

  localparam int N_STG    = 3;
  localparam int LOAD_LAT = 1;
  localparam int RA_W     = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            id_valid = 1'b0;
  logic [RA_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic            id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic            id_reg_write = 1'b0, id_is_load = 1'b0;
  logic            id_branch = 1'b0, id_redirect = 1'b0;
  logic            stall, if_id_flush;
  logic [2:0]      id_fwd_a, id_fwd_b, exe_fwd_a, exe_fwd_b;
`ifdef HAZ_STATS_EN
  logic [31:0]     stall_cnt, loaduse_cnt;
`endif

  always #5 clock = ~clock;

  pipe_hazard_unit #(.N_STG(N_STG), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_branch    (id_branch),
    .id_redirect  (id_redirect),
    .stall        (stall),
    .if_id_flush  (if_id_flush),
    .id_fwd_a     (id_fwd_a),
    .id_fwd_b     (id_fwd_b),
    .exe_fwd_a    (exe_fwd_a),
    .exe_fwd_b    (exe_fwd_b)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .loaduse_cnt  (loaduse_cnt)
`endif
  );

  // Reference model: history of issued register writers with issue time.
  typedef struct {
    int              c;
    logic [RA_W-1:0] rd;
    bit              ld;
  } rec_t;

  rec_t q[$];
  int   now;
  int   errors;
  int   checks;
  int   exp_exe_a, exp_exe_b;
  int   m_stall, m_flush, m_idfa, m_idfb, m_exa_nxt, m_exb_nxt, m_lu;
  int   exp_stall_cnt, exp_lu_cnt, prev_lu;

  function automatic int age_of(logic [RA_W-1:0] r);
    int k = 0;
    if (r != '0) begin
      foreach (q[i]) begin
        if (q[i].rd == r && (now - q[i].c) >= 1 && (now - q[i].c) <= N_STG)
          k = now - q[i].c;
      end
    end
    return k;
  endfunction

  function automatic bit ld_of(logic [RA_W-1:0] r);
    bit l = 1'b0;
    if (r != '0) begin
      foreach (q[i]) begin
        if (q[i].rd == r && (now - q[i].c) >= 1 && (now - q[i].c) <= N_STG)
          l = q[i].ld;
      end
    end
    return l;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    int ka, kb;
    bit la, lb, lu, br;
    ka = age_of(id_rs);
    kb = age_of(id_rt);
    la = ld_of(id_rs);
    lb = ld_of(id_rt);
    lu = (id_use_rs && ka != 0 && la && ka <= LOAD_LAT) ||
         (id_use_rt && kb != 0 && lb && kb <= LOAD_LAT);
    br = id_branch &&
         ((id_use_rs && ka != 0 && (ka == 1 || (la && ka <= LOAD_LAT + 1))) ||
          (id_use_rt && kb != 0 && (kb == 1 || (lb && kb <= LOAD_LAT + 1))));
    m_stall   = (id_valid && (lu || br)) ? 1 : 0;
    m_lu      = (id_valid && lu) ? 1 : 0;
    m_flush   = (id_redirect && m_stall == 0) ? 1 : 0;
    m_idfa    = (id_valid && m_stall == 0 && ka >= 2) ? ka : 0;
    m_idfb    = (id_valid && m_stall == 0 && kb >= 2) ? kb : 0;
    m_exa_nxt = (m_stall == 0 && ka >= 1 && ka <= N_STG - 1) ? ka : 0;
    m_exb_nxt = (m_stall == 0 && kb >= 1 && kb <= N_STG - 1) ? kb : 0;
  endtask

  task automatic drive(input bit v, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                       input bit urs, input bit urt, input logic [RA_W-1:0] rd,
                       input bit rw, input bit ld, input bit br, input bit rdr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; id_branch = br; id_redirect = rdr;
  endtask

  // One clock: check combinational outputs, advance model, check EXE selects.
  task automatic cycle();
    #1;
    model_eval();
    chk("stall", int'(stall), m_stall);
    chk("if_id_flush", int'(if_id_flush), m_flush);
    chk("id_fwd_a", int'(id_fwd_a), m_idfa);
    chk("id_fwd_b", int'(id_fwd_b), m_idfb);
    @(posedge clock);
    if (m_stall == 0 && id_valid && id_reg_write)
      q.push_back('{c: now, rd: id_rd, ld: id_is_load});
    exp_stall_cnt += m_stall;
    if (m_lu != 0 && prev_lu == 0) exp_lu_cnt++;
    prev_lu   = m_lu;
    exp_exe_a = m_exa_nxt;
    exp_exe_b = m_exb_nxt;
    now++;
    while (q.size() > 0 && (now - q[0].c) > N_STG) q.delete(0);
    #1;
    chk("exe_fwd_a", int'(exe_fwd_a), exp_exe_a);
    chk("exe_fwd_b", int'(exe_fwd_b), exp_exe_b);
  endtask

  task automatic model_reset();
    q.delete();
    exp_exe_a = 0; exp_exe_b = 0;
    exp_stall_cnt = 0; exp_lu_cnt = 0; prev_lu = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", int'(stall), 0);
    chk("rst_exe_fwd_a", int'(exe_fwd_a), 0);
    chk("rst_exe_fwd_b", int'(exe_fwd_b), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    errors = 0; checks = 0; now = 0;
    model_reset();

    // Reset state
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_flush", int'(if_id_flush), 0);
    chk("reset_id_fwd_a", int'(id_fwd_a), 0);
    chk("reset_id_fwd_b", int'(id_fwd_b), 0);
    chk("reset_exe_fwd_a", int'(exe_fwd_a), 0);
    chk("reset_exe_fwd_b", int'(exe_fwd_b), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Load-use: lw $2 ; add $3,$2,$4
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); cycle();
    drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);
    #1; chk("lu_stall_on", int'(stall), 1);
    cycle();
    #1; chk("lu_stall_off", int'(stall), 0);
    cycle();
    chk("lu_exe_fwd_a", int'(exe_fwd_a), 2);
    chk("lu_exe_fwd_b", int'(exe_fwd_b), 0);
    nops(3);

    // ALU chain: add $5 ; sub $6,$5,$5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle();
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    #1; chk("alu_no_stall", int'(stall), 0);
    cycle();
    chk("alu_exe_fwd_a", int'(exe_fwd_a), 1);
    chk("alu_exe_fwd_b", int'(exe_fwd_b), 1);
    nops(3);

    // Branch after ALU: add $7 ; beq $7,$0 taken
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle();
    drive(1, 7, 0, 1, 1, 0, 0, 0, 1, 1);
    #1; chk("br_alu_stall", int'(stall), 1);
    chk("br_alu_flush_held", int'(if_id_flush), 0);
    cycle();
    #1; chk("br_alu_release", int'(stall), 0);
    chk("br_alu_id_fwd_a", int'(id_fwd_a), 2);
    chk("br_alu_flush", int'(if_id_flush), 1);
    cycle();
    nops(3);

    // Register 0: lw $0 ; add $1,$0,$0
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    #1; chk("r0_no_stall", int'(stall), 0);
    chk("r0_id_fwd_a", int'(id_fwd_a), 0);
    cycle();
    chk("r0_exe_fwd_a", int'(exe_fwd_a), 0);
    chk("r0_exe_fwd_b", int'(exe_fwd_b), 0);
    nops(3);

    // Branch after load: lw $8 ; beq $8 stalls LOAD_LAT+1 cycles
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); cycle();
    drive(1, 8, 0, 1, 0, 0, 0, 0, 1, 0);
    #1; chk("br_ld_stall1", int'(stall), 1);
    cycle();
    #1; chk("br_ld_stall2", int'(stall), 1);
    cycle();
    #1; chk("br_ld_release", int'(stall), 0);
    chk("br_ld_id_fwd_a", int'(id_fwd_a), 3);
    cycle();
    nops(3);

    // id_valid low masks a load-use hazard
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); cycle();
    drive(0, 9, 9, 1, 1, 0, 0, 0, 1, 0);
    #1; chk("inv_no_stall", int'(stall), 0);
    chk("inv_id_fwd_b", int'(id_fwd_b), 0);
    cycle();
    nops(3);

    // Reset mid-stall
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); cycle();
    drive(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
    #1; chk("rms_stall_on", int'(stall), 1);
    do_reset();
    #1; chk("rms_after_release", int'(stall), 0);
    cycle();
    nops(3);

`ifdef HAZ_STATS_EN
    // Three load-use pairs from a clean reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); cycle();
      drive(1, 2, 2, 1, 1, 3, 1, 0, 0, 0); cycle(); cycle();
    end
    chk("stats_loaduse_cnt", int'(loaduse_cnt), 3);
    chk("stats_stall_cnt", int'(stall_cnt), 3);
`endif

    // Random instruction streams over a small register set
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) < 85),
            RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            RA_W'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cycle();
    end

`ifdef HAZ_STATS_EN
    chk("rand_stall_cnt", int'(stall_cnt), exp_stall_cnt);
    chk("rand_loaduse_cnt", int'(loaduse_cnt), exp_lu_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
